// File: rtl/relu_maxpool_stage.sv
// ReLU + 2x2 max-pool stage between the conv result bus and the result-memory writer.
// Lane pairs are pooled horizontally in the same cycle a row arrives. Row pairs are
// pooled vertically through a one-row buffer. A trailing odd row is flushed on its own.
module relu_maxpool_stage #(
  parameter int unsigned Lanes = 128,
  parameter int unsigned Dw    = 8,
  parameter int unsigned Rows  = 128,
  parameter int unsigned AddrW = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       in_valid_i,
  input  logic [Lanes*Dw-1:0]        in_data_i,
  output logic [(Lanes/2)*Dw-1:0]    out_data_o,
  output logic                       out_wen_o,
  output logic [AddrW-1:0]           out_addr_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int unsigned OutW = (Lanes / 2) * Dw;
  localparam int unsigned CntW = $clog2(Rows + 1);

  typedef enum logic [2:0] {StIdle, StFirst, StSecond, StFlush, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   row_cnt_q, row_cnt_d;
  logic [OutW-1:0]   buf_q, buf_d;
  logic [OutW-1:0]   out_data_q, out_data_d;
  logic              out_wen_q, out_wen_d;
  logic [AddrW-1:0]  addr_q, addr_d;
  logic [OutW-1:0]   hpool, vpool;
  logic              row_last;

  function automatic logic [Dw-1:0] relu(input logic [Dw-1:0] x);
    return x[Dw-1] ? '0 : x;
  endfunction

  // Inputs are already non-negative here, so an unsigned compare is exact.
  function automatic logic [Dw-1:0] umax(input logic [Dw-1:0] a, input logic [Dw-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // ReLU then horizontal lane-pair max; vertical max against the buffered row
  always_comb begin
    hpool = '0;
    vpool = '0;
    for (int unsigned j = 0; j < Lanes / 2; j++) begin
      hpool[j*Dw +: Dw] = umax(relu(in_data_i[(2*j)*Dw +: Dw]),
                               relu(in_data_i[(2*j+1)*Dw +: Dw]));
      vpool[j*Dw +: Dw] = umax(buf_q[j*Dw +: Dw], hpool[j*Dw +: Dw]);
    end
  end

  // The row being accepted now is the last one of the frame
  assign row_last = (row_cnt_q == CntW'(Rows - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start_i) state_d = StFirst;
      StFirst:  if (in_valid_i) state_d = row_last ? StFlush : StSecond;
      StSecond: if (in_valid_i) state_d = row_last ? StDone : StFirst;
      StFlush:  state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      StFirst, StSecond, StFlush: busy_o = 1'b1;
      StDone:                     done_o = 1'b1;
      default:                    ;
    endcase
  end

  // Datapath next-state: buffer, row counter, registered write port
  always_comb begin
    row_cnt_d  = row_cnt_q;
    buf_d      = buf_q;
    out_data_d = out_data_q;
    out_wen_d  = 1'b0;
    // Address advances the cycle after each strobe; wraps silently.
    addr_d     = out_wen_q ? addr_q + 1'b1 : addr_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          row_cnt_d = '0;
          buf_d     = '0;
          addr_d    = '0;
        end
      end
      StFirst: begin
        if (in_valid_i) begin
          buf_d     = hpool;
          row_cnt_d = row_cnt_q + 1'b1;
        end
      end
      StSecond: begin
        if (in_valid_i) begin
          out_data_d = vpool;
          out_wen_d  = 1'b1;
          row_cnt_d  = row_cnt_q + 1'b1;
        end
      end
      StFlush: begin
        // Max against an all-zero row is the buffer itself.
        out_data_d = buf_q;
        out_wen_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_cnt_q  <= '0;
      buf_q      <= '0;
      out_data_q <= '0;
      out_wen_q  <= 1'b0;
      addr_q     <= '0;
    end else begin
      row_cnt_q  <= row_cnt_d;
      buf_q      <= buf_d;
      out_data_q <= out_data_d;
      out_wen_q  <= out_wen_d;
      addr_q     <= addr_d;
    end
  end

  assign out_data_o = out_data_q;
  assign out_wen_o  = out_wen_q;
  assign out_addr_o = addr_q;

endmodule

// File: tb/tb_relu_maxpool_stage.sv
// Scoreboard bench for relu_maxpool_stage: three instances (128 rows, 5 rows, 40 rows with
// a 4-bit address) share the row bus; only one is running a frame at a time.
module tb_relu_maxpool_stage;

  localparam int unsigned IW = 1024;
  localparam int unsigned OW = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, start_a, start_b, start_c;
  logic [IW-1:0] in_data;

  logic [OW-1:0] data_a, data_b, data_c;
  logic          wen_a, wen_b, wen_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [7:0]    addr_a, addr_b;
  logic [3:0]    addr_c;

  relu_maxpool_stage #(.Lanes(128), .Dw(8), .Rows(128), .AddrW(8)) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .in_valid_i(in_valid), .in_data_i(in_data),
    .out_data_o(data_a), .out_wen_o(wen_a), .out_addr_o(addr_a), .busy_o(busy_a),
    .done_o(done_a)
  );
  relu_maxpool_stage #(.Lanes(128), .Dw(8), .Rows(5), .AddrW(8)) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .in_valid_i(in_valid), .in_data_i(in_data),
    .out_data_o(data_b), .out_wen_o(wen_b), .out_addr_o(addr_b), .busy_o(busy_b),
    .done_o(done_b)
  );
  relu_maxpool_stage #(.Lanes(128), .Dw(8), .Rows(40), .AddrW(4)) u_c (
    .clk_i(clk), .rst_i(rst), .start_i(start_c), .in_valid_i(in_valid), .in_data_i(in_data),
    .out_data_o(data_c), .out_wen_o(wen_c), .out_addr_o(addr_c), .busy_o(busy_c),
    .done_o(done_c)
  );

  typedef struct {
    logic [7:0]    addr;
    logic [OW-1:0] data;
  } exp_t;

  exp_t q_a[$], q_b[$], q_c[$];
  int   cmps = 0, errs = 0;
  int   dcnt_a = 0, dcnt_b = 0, dcnt_c = 0;
  int   ea_a = 0, ea_b = 0, ea_c = 0;

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: ReLU + lane-pair max, and lane-wise max of two pooled rows
  function automatic logic [OW-1:0] hp(input logic [IW-1:0] r);
    logic [OW-1:0] o;
    logic [7:0]    a, b;
    for (int j = 0; j < 64; j++) begin
      a = r[16*j +: 8];
      b = r[16*j+8 +: 8];
      if (a[7]) a = 8'h00;
      if (b[7]) b = 8'h00;
      o[8*j +: 8] = (a > b) ? a : b;
    end
    return o;
  endfunction

  function automatic logic [OW-1:0] vm(input logic [OW-1:0] x, input logic [OW-1:0] y);
    logic [OW-1:0] o;
    for (int j = 0; j < 64; j++) o[8*j +: 8] = (x[8*j +: 8] > y[8*j +: 8]) ? x[8*j +: 8] : y[8*j +: 8];
    return o;
  endfunction

  function automatic logic [IW-1:0] rand_row();
    logic [IW-1:0] r;
    for (int k = 0; k < 32; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: pop and compare on every write strobe, count done pulses
  always @(negedge clk) begin
    exp_t e;
    if (wen_a) begin
      if (q_a.size() == 0) chk("unexpected_write_a", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("addr_a", OW'(addr_a), OW'(e.addr));
        chk("data_a", data_a, e.data);
      end
    end
    if (wen_b) begin
      if (q_b.size() == 0) chk("unexpected_write_b", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("addr_b", OW'(addr_b), OW'(e.addr));
        chk("data_b", data_b, e.data);
      end
    end
    if (wen_c) begin
      if (q_c.size() == 0) chk("unexpected_write_c", 1, 0);
      else begin
        e = q_c.pop_front();
        chk("addr_c", OW'(addr_c), OW'(e.addr));
        chk("data_c", data_c, e.data);
      end
    end
    if (done_a) dcnt_a++;
    if (done_b) dcnt_b++;
    if (done_c) dcnt_c++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic row(input logic [IW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cyc();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic push(input int which, input logic [OW-1:0] d);
    case (which)
      0: begin q_a.push_back('{8'(ea_a), d}); ea_a = (ea_a + 1) % 256; end
      1: begin q_b.push_back('{8'(ea_b), d}); ea_b = (ea_b + 1) % 256; end
      default: begin q_c.push_back('{8'(ea_c), d}); ea_c = (ea_c + 1) % 16; end
    endcase
  endtask

  task automatic start(input int which);
    case (which)
      0: begin start_a = 1'b1; ea_a = 0; end
      1: begin start_b = 1'b1; ea_b = 0; end
      default: begin start_c = 1'b1; ea_c = 0; end
    endcase
    cyc();
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  function automatic int dcnt(input int which);
    return (which == 0) ? dcnt_a : (which == 1) ? dcnt_b : dcnt_c;
  endfunction

  // Bounded wait for the frame's done pulse; then confirm exactly one and busy low
  task automatic wait_done(input string nm, input int which, input int target);
    int n = 0;
    in_valid = 1'b0;
    while (dcnt(which) < target && n < 400) begin
      cyc();
      n++;
    end
    idle(3);
    chk({nm, "_done_count"}, OW'(dcnt(which)), OW'(target));
    chk({nm, "_busy_after"}, OW'((which == 0) ? busy_a : (which == 1) ? busy_b : busy_c), 0);
  endtask

  initial begin
    logic [IW-1:0] r0, r1, r;
    logic [OW-1:0] e, prev;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", OW'(busy_a), 0);
    chk("rst_addr", OW'(addr_a), 0);
    cyc();

    // 1. Reset mid-frame: one write lands, then reset while a row is buffered
    start(0);
    @(negedge clk);
    chk("busy_after_start", OW'(busy_a), 1);
    r0 = rand_row(); r1 = rand_row();
    row(r0); push(0, vm(hp(r0), hp(r1))); row(r1);
    idle(2);
    row(rand_row());
    rst = 1'b1; in_valid = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    chk("midrst_wen", OW'(wen_a), 0);
    chk("midrst_addr", OW'(addr_a), 0);
    chk("midrst_busy", OW'(busy_a), 0);
    chk("midrst_done", OW'(done_a), 0);
    chk("midrst_data", data_a, 0);
    cyc();
    rst = 1'b0;
    idle(3);
    chk("midrst_no_done", OW'(dcnt_a), 0);

    // 2. ReLU / hmax, restart at address 0, one-cycle latency
    start(0);
    r0 = '0; r0[15:0] = 16'h05F0; r0[1023:1008] = 16'h4241;
    r1 = '0; r1[15:0] = 16'h8003;
    e = '0; e[7:0] = 8'h05; e[511:504] = 8'h42;
    row(r0); push(0, e); row(r1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_wen", OW'(wen_a), 1);
    idle(2);
    chk("data_holds", data_a, e);

    // 3. Vertical max, then an all-negative pair
    r0 = '0; r0[15:0] = 16'h2010;
    r1 = '0; r1[15:0] = 16'h007F;
    e = '0; e[7:0] = 8'h7F;
    row(r0); push(0, e); row(r1);
    idle(1);
    r0 = {128{8'h9C}};
    row(r0); push(0, '0); row({128{8'hFF}});
    // finish this frame with random rows: 61 more pairs
    for (int i = 0; i < 122; i++) begin
      r = rand_row();
      if (i % 2 == 0) prev = hp(r);
      else push(0, vm(prev, hp(r)));
      row(r);
    end
    wait_done("frame1", 0, 1);

    // 4. Full frame, in_valid held high: 64 writes at addresses 0..63
    start(0);
    for (int i = 0; i < 128; i++) begin
      r = rand_row();
      if (i % 2 == 0) prev = hp(r);
      else push(0, vm(prev, hp(r)));
      row(r);
    end
    wait_done("frame2", 0, 2);

    // 5. Odd frame with gaps, extra starts, rows offered on the start/FLUSH/DONE cycles
    start_b = 1'b1; ea_b = 0; in_valid = 1'b1; in_data = {128{8'h7E}};
    cyc();
    start_b = 1'b0;
    r0 = rand_row(); r1 = rand_row();
    row(r0); idle(2); push(1, vm(hp(r0), hp(r1))); row(r1); idle(1);
    start_b = 1'b1; cyc(); start_b = 1'b0;
    r0 = rand_row(); r1 = rand_row();
    row(r0); push(1, vm(hp(r0), hp(r1))); row(r1);
    in_valid = 1'b0; start_b = 1'b1; cyc(); start_b = 1'b0; idle(2);
    r = rand_row();
    push(1, hp(r)); row(r);
    in_data = {128{8'h7F}};
    cyc(); cyc();
    wait_done("frame_odd", 1, 1);

    // 6. 40 rows with a 4-bit address: 0..15 then wrap 0..3
    start(2);
    for (int i = 0; i < 40; i++) begin
      r = rand_row();
      if (i % 2 == 0) prev = hp(r);
      else push(2, vm(prev, hp(r)));
      row(r);
    end
    wait_done("frame_wrap", 2, 1);

    chk("drain_a", OW'(q_a.size()), 0);
    chk("drain_b", OW'(q_b.size()), 0);
    chk("drain_c", OW'(q_c.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
